// File: rtl/disp_pkg.sv
// Shared types and the hex-to-segment table for the multiplexed 7-segment display driver.
package disp_pkg;

    localparam int NUM_DIGITS = 8;

    typedef logic [3:0] nibble_t;
    typedef logic [6:0] seg7_t;

    // Active-high {g,f,e,d,c,b,a}; polarity is applied at the pins.
    function automatic seg7_t hex_to_seg7(input nibble_t nib);
        seg7_t s;
        case (nib)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/hex7seg_dec.sv
// Combinational nibble-to-segment decoder (active-high segments).
module hex7seg_dec
    import disp_pkg::*;
(
    input  nibble_t nib_i,
    output seg7_t   seg_o
);

    assign seg_o = hex_to_seg7(nib_i);

endmodule

// File: rtl/seg7_scan_drv.sv
// Scans a 32-bit shadow value across 8 multiplexed hex digits with per-slot blanking
// and optional leading-zero suppression; outputs are registered.
module seg7_scan_drv
    import disp_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int BLANK_CYC   = 16,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           data_in,
    input  logic                  load,
    input  logic                  blank_lz,
    output logic [NUM_DIGITS-1:0] an,
    output logic [6:0]            seg,
    output logic                  dp
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYC);

    logic [31:0]           shadow_q, shadow_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    seg7_t                 seg_q, seg_d;

    logic [NUM_DIGITS-1:0] lz_blank;
    logic                  nz_above;
    nibble_t               cur_nib;
    seg7_t                 cur_seg;

    always_comb begin
        shadow_d = load ? data_in : shadow_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = idx_q + 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
            idx_d = idx_q;
        end
    end

    // A digit is a leading zero when it and every digit above it are zero; digit 0 never is.
    always_comb begin
        lz_blank = '0;
        nz_above = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            nz_above    = nz_above | (shadow_q[4*i +: 4] != 4'h0);
            lz_blank[i] = blank_lz & ~nz_above;
        end
    end

    assign cur_nib = shadow_q[{idx_q, 2'b00} +: 4];

    hex7seg_dec u_dec (
        .nib_i (cur_nib),
        .seg_o (cur_seg)
    );

    always_comb begin
        an_d  = '0;
        seg_d = '0;
        if ((cnt_q >= CNT_BLANK) && !lz_blank[idx_q]) begin
            an_d[idx_q] = 1'b1;
            seg_d       = cur_seg;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow_q <= '0;
            cnt_q    <= '0;
            idx_q    <= '0;
            an_q     <= '0;
            seg_q    <= '0;
        end else begin
            shadow_q <= shadow_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
        end
    end

    assign an  = ACTIVE_LOW ? ~an_q  : an_q;
    assign seg = ACTIVE_LOW ? ~seg_q : seg_q;
    assign dp  = ACTIVE_LOW;

endmodule

// File: tb/tb_seg7_scan_drv.sv
// Bench for seg7_scan_drv: cycle scoreboard from a behavioural display model plus directed
// checks of scan order, blank phase, leading zeros, mid-scan load and reset.
module tb_seg7_scan_drv;

    localparam int RD = 4;
    localparam int BC = 1;
    localparam logic [15:0] BLANK_OUT = {1'b1, 8'hFF, 7'h7F};

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        load = 1'b0;
    logic        blank_lz = 1'b0;
    logic [31:0] data_in = 32'h0;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int n_cmp = 0;
    int n_err = 0;

    seg7_scan_drv #(
        .REFRESH_DIV (RD),
        .BLANK_CYC   (BC),
        .ACTIVE_LOW  (1'b1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .data_in  (data_in),
        .load     (load),
        .blank_lz (blank_lz),
        .an       (an),
        .seg      (seg),
        .dp       (dp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pin-level (active-low) segment pattern for a nibble.
    function automatic logic [6:0] ref_seg(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h3F; 4'h1: s = 7'h06; 4'h2: s = 7'h5B; 4'h3: s = 7'h4F;
            4'h4: s = 7'h66; 4'h5: s = 7'h6D; 4'h6: s = 7'h7D; 4'h7: s = 7'h07;
            4'h8: s = 7'h7F; 4'h9: s = 7'h6F; 4'hA: s = 7'h77; 4'hB: s = 7'h7C;
            4'hC: s = 7'h39; 4'hD: s = 7'h5E; 4'hE: s = 7'h79; default: s = 7'h71;
        endcase
        return ~s;
    endfunction

    function automatic logic [15:0] ref_out(input logic [31:0] sh, input int idx, input int cnt,
                                            input logic blz);
        logic [7:0] one_hot;
        if (cnt < BC) return BLANK_OUT;
        if (idx >= 1 && blz && ((sh >> (4 * idx)) == 32'h0)) return BLANK_OUT;
        one_hot = 8'h01 << idx;
        return {1'b1, ~one_hot, ref_seg(sh[4*idx +: 4])};
    endfunction

    logic [31:0] m_sh = 32'h0;
    int          m_idx = 0;
    int          m_cnt = 0;
    logic [15:0] sb_q[$];

    always @(posedge clk) begin
        if (!rst) begin
            sb_q.push_back(BLANK_OUT);
            m_sh  <= 32'h0;
            m_idx <= 0;
            m_cnt <= 0;
        end else begin
            sb_q.push_back(ref_out(m_sh, m_idx, m_cnt, blank_lz));
            if (load) m_sh <= data_in;
            if (m_cnt == RD - 1) begin
                m_cnt <= 0;
                m_idx <= (m_idx + 1) % 8;
            end else begin
                m_cnt <= m_cnt + 1;
            end
        end
    end

    always @(negedge clk) begin
        logic [15:0] exp;
        if (sb_q.size() > 0) begin
            exp = sb_q.pop_front();
            chk("scoreboard", {16'h0, dp, an, seg}, {16'h0, exp});
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_lit(input int k, input int budget);
        bit found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk);
            if (an === ~(8'h01 << k)) found = 1'b1;
        end
        if (!found) chk($sformatf("timeout_digit%0d", k), 32'd0, 32'd1);
    endtask

    logic [7:0] cap_mask;
    logic [6:0] cap_seg[8];

    task automatic capture_frame();
        cap_mask = 8'h00;
        for (int j = 0; j < 8; j++) cap_seg[j] = 7'h7F;
        for (int c = 0; c < 8 * RD; c++) begin
            @(negedge clk);
            for (int j = 0; j < 8; j++) begin
                if (an[j] === 1'b0) begin
                    cap_mask[j] = 1'b1;
                    cap_seg[j]  = seg;
                end
            end
        end
    endtask

    task automatic load_value(input logic [31:0] v, input logic blz);
        step();
        blank_lz = blz;
        data_in  = v;
        load     = 1'b1;
        step();
        load     = 1'b0;
    endtask

    logic [6:0] scan_seg[8] = '{7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00};

    initial begin
        #100000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1);
    end

    initial begin
        int run;

        repeat (3) @(negedge clk);
        chk("reset_an", {24'h0, an}, 32'hFF);
        chk("reset_seg", {25'h0, seg}, 32'h7F);
        chk("reset_dp", {31'h0, dp}, 32'h1);
        #1 rst = 1'b1;

        wait_lit(0, 8);
        chk("first_lit_seg", {25'h0, seg}, 32'h40);

        load_value(32'h89AB_CDEF, 1'b0);
        wait_lit(7, 40);
        for (int k = 0; k < 8; k++) begin
            wait_lit(k, 8);
            chk($sformatf("scan_seg%0d", k), {25'h0, seg}, {25'h0, scan_seg[k]});
        end
        wait_lit(0, 8);
        chk("scan_wrap_an", {24'h0, an}, 32'hFE);

        for (int s = 0; s < 8; s++) begin
            run = 0;
            for (int i = 0; i < 8 && an !== 8'hFF; i++) @(negedge clk);
            while (an === 8'hFF && run < 10) begin
                run++;
                @(negedge clk);
            end
            chk($sformatf("blank_run%0d", s), run, 1);
        end

        load_value(32'h0000_0A05, 1'b1);
        repeat (2) @(negedge clk);
        capture_frame();
        chk("lz_mask", {24'h0, cap_mask}, 32'h07);
        chk("lz_seg0", {25'h0, cap_seg[0]}, 32'h12);
        chk("lz_seg1", {25'h0, cap_seg[1]}, 32'h40);
        chk("lz_seg2", {25'h0, cap_seg[2]}, 32'h08);

        load_value(32'h0, 1'b1);
        repeat (2) @(negedge clk);
        capture_frame();
        chk("zero_mask", {24'h0, cap_mask}, 32'h01);
        chk("zero_seg0", {25'h0, cap_seg[0]}, 32'h40);

        load_value(32'h89AB_CDEF, 1'b0);
        wait_lit(2, 40);
        wait_lit(3, 8);
        chk("mid_old_seg", {25'h0, seg}, 32'h46);
        #1;
        data_in = 32'h1234_5678;
        load    = 1'b1;
        @(negedge clk);
        #1 load = 1'b0;
        @(negedge clk);
        chk("mid_new_an", {24'h0, an}, 32'hF7);
        chk("mid_new_seg", {25'h0, seg}, 32'h12);
        wait_lit(4, 4);
        chk("mid_next_seg", {25'h0, seg}, 32'h19);

        #1;
        data_in = 32'hFFFF_FFFF;
        load    = 1'b1;
        rst     = 1'b0;
        #1;
        chk("rst_now_an", {24'h0, an}, 32'hFF);
        chk("rst_now_seg", {25'h0, seg}, 32'h7F);
        chk("rst_now_dp", {31'h0, dp}, 32'h1);
        step();
        step();
        rst  = 1'b1;
        load = 1'b0;
        wait_lit(0, 8);
        chk("rst_d0_seg", {25'h0, seg}, 32'h40);
        wait_lit(1, 8);
        chk("rst_d1_seg", {25'h0, seg}, 32'h40);

        repeat (2) @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
